// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: sequencer state encoding and opcode constants shared by the CPU cycle sequencer
package cpu_seq_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  localparam logic [5:0] OP_HALT    = 6'd0;
  localparam logic [5:0] OP_ALU_MIN = 6'd1;
  localparam logic [5:0] OP_ALU_MAX = 6'd23;
  localparam logic [5:0] OP_LW      = 6'd24;
  localparam logic [5:0] OP_SW      = 6'd25;
  localparam logic [5:0] OP_LB      = 6'd26;
  localparam logic [5:0] OP_SB      = 6'd27;
  localparam logic [5:0] OP_J       = 6'd28;
  localparam logic [5:0] OP_JR      = 6'd29;
  function automatic logic is_store(input logic [5:0] op);
    return op == OP_SW || op == OP_SB;
  endfunction
  function automatic logic is_byte(input logic [5:0] op);
    return op == OP_LB || op == OP_SB;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags expiry on the last allowed wait cycle.
//   clk, rst_n (async active-low); run_i = sequencer is in a memory-wait state;
//   ack_i = memory acknowledge; expire_o = this is wait cycle MEM_TIMEOUT with no ack.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic ack_i,
  output logic expire_o
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  // Leaving a wait state always passes through ack, expiry or a non-wait state, so
  // clearing whenever run_i is low or ack arrives covers every state change.
  always_comb cnt_d = (run_i && !ack_i) ? cnt_q + 1'b1 : '0;
  assign expire_o = run_i && !ack_i && cnt_q == W'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port.
//   clk; rst (async active-low); opcode = IR[31:26]; mem_ack = memory completes request.
//   mem_req/mem_we/mem_byte/mem_addr_sel drive the memory port; ir_load, pc_en,
//   reg_we_word, reg_we_byte gate IR/PC/regfile; halted, illegal, timeout status; instret count.
//   Define SEQ_MEM_TIMEOUT_EN to abandon memory waits after MEM_TIMEOUT cycles.
module cpu_cycle_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_byte,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_en,
  output logic             reg_we_word,
  output logic             reg_we_byte,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instret
);
  state_e state_q, state_d;
  logic illegal_q, illegal_d, timeout_q, timeout_d, retire, expire;
  logic [CNT_W-1:0] instret_q, instret_d;
`ifdef SEQ_MEM_TIMEOUT_EN
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst),
    .run_i   (state_q == S_FETCH || state_q == S_MEM),
    .ack_i   (mem_ack),
    .expire_o(expire)
  );
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_byte     = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    reg_we_word  = 1'b0;
    reg_we_byte  = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
        if (expire) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else if (mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d   = (opcode == OP_HALT || opcode[5]) ? S_HALT : S_EXEC;
        illegal_d = illegal_q | opcode[5];
      end
      S_EXEC: begin
        pc_en   = opcode >= OP_J;
        retire  = opcode >= OP_J;
        state_d = opcode >= OP_J ? S_FETCH : opcode >= OP_LW ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store(opcode);
        mem_byte     = is_byte(opcode);
        // Stores retire on the ack cycle itself; loads still need the WB cycle.
        pc_en        = mem_ack && is_store(opcode);
        retire       = mem_ack && is_store(opcode);
        if (expire) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else if (mem_ack) state_d = is_store(opcode) ? S_FETCH : S_WB;
      end
      S_WB: begin
        pc_en       = 1'b1;
        retire      = 1'b1;
        reg_we_byte = opcode == OP_LB;
        reg_we_word = opcode != OP_LB;
        state_d     = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Reset is asynchronous, so strobes are masked combinationally to die the moment rst falls.
    {mem_req, ir_load, pc_en, reg_we_word, reg_we_byte} &= {5{rst}};
    instret_d = instret_q + CNT_W'(retire);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      instret_q <= instret_d;
    end
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign instret = instret_q;
endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// tb_cpu_cycle_sequencer: directed per-cycle vectors checked through an expectation queue
module tb_cpu_cycle_sequencer;
  localparam logic [10:0] REQ = 11'h400, WE = 11'h200, BY = 11'h100, SEL = 11'h080,
                          IRL = 11'h040, PC = 11'h020, RWW = 11'h010, RWB = 11'h008,
                          HLT = 11'h004, ILL = 11'h002, TMO = 11'h001;
  typedef struct packed {
    logic [10:0] flags;
    logic [31:0] cnt;
    int          id;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, mem_ack = 1'b0;
  logic [5:0] opcode = '0;
  logic mem_req, mem_we, mem_byte, mem_addr_sel, ir_load, pc_en, reg_we_word, reg_we_byte;
  logic halted, illegal, timeout;
  logic [31:0] instret;
  exp_t q[$];
  int checks = 0, failures = 0, step_id = 0;
  cpu_cycle_sequencer #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr_sel(mem_addr_sel),
    .ir_load(ir_load), .pc_en(pc_en), .reg_we_word(reg_we_word), .reg_we_byte(reg_we_byte),
    .halted(halted), .illegal(illegal), .timeout(timeout), .instret(instret)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    logic [10:0] act;
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      act = {mem_req, mem_we, mem_byte, mem_addr_sel, ir_load, pc_en, reg_we_word,
             reg_we_byte, halted, illegal, timeout};
      checks++;
      if (act !== e.flags || instret !== e.cnt) begin
        failures++;
        $display("FAIL step%0d flags act=%b exp=%b instret act=%0d exp=%0d",
                 e.id, act, e.flags, instret, e.cnt);
      end
    end
  end
  task automatic step(input logic r, input logic [5:0] op, input logic ack,
                      input logic [10:0] fl, input logic [31:0] cnt);
    @(posedge clk);
    #1;
    rst = r;
    opcode = op;
    mem_ack = ack;
    step_id++;
    q.push_back('{flags: fl, cnt: cnt, id: step_id});
  endtask
  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // ALU op 1, immediate ack: ir_load c1, reg_we_word + pc_en c4
    step(1, 1, 1, REQ | IRL, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, RWW | PC, 0);
    // lb, three MEM wait cycles: 8 cycles total
    step(1, 26, 1, REQ | IRL, 1);
    step(1, 26, 0, 0, 1);
    step(1, 26, 0, 0, 1);
    step(1, 26, 0, REQ | BY | SEL, 1);
    step(1, 26, 0, REQ | BY | SEL, 1);
    step(1, 26, 0, REQ | BY | SEL, 1);
    step(1, 26, 1, REQ | BY | SEL, 1);
    step(1, 26, 0, RWB | PC, 1);
    // sw, immediate ack: pc_en on the ack cycle, no regfile write
    step(1, 25, 1, REQ | IRL, 2);
    step(1, 25, 0, 0, 2);
    step(1, 25, 0, 0, 2);
    step(1, 25, 1, REQ | WE | SEL | PC, 2);
    // jump: 3 cycles
    step(1, 28, 1, REQ | IRL, 3);
    step(1, 28, 0, 0, 3);
    step(1, 28, 0, PC, 3);
    // lw with one fetch wait cycle
    step(1, 24, 0, REQ, 4);
    step(1, 24, 1, REQ | IRL, 4);
    step(1, 24, 0, 0, 4);
    step(1, 24, 0, 0, 4);
    step(1, 24, 1, REQ | SEL, 4);
    step(1, 24, 0, RWW | PC, 4);
    // opcode 0 halts; ack in HALT is ignored
    step(1, 0, 1, REQ | IRL, 5);
    step(1, 0, 0, 0, 5);
    step(1, 0, 1, HLT, 5);
    step(1, 0, 1, HLT, 5);
    // reset clears everything, then illegal opcode 40
    step(0, 0, 0, 0, 0);
    step(1, 40, 1, REQ | IRL, 0);
    step(1, 40, 0, 0, 0);
    step(1, 40, 1, HLT | ILL, 0);
    step(1, 40, 1, HLT | ILL, 0);
    // reset asserted mid-MEM wait of sb: mem_req drops in the same cycle
    step(0, 0, 0, 0, 0);
    step(1, 27, 1, REQ | IRL, 0);
    step(1, 27, 0, 0, 0);
    step(1, 27, 0, 0, 0);
    step(1, 27, 0, REQ | WE | BY | SEL, 0);
    step(0, 27, 0, 0, 0);
    step(1, 24, 0, REQ, 0);
    // lw with no ack in MEM: abandoned after 4 wait cycles only when the timer is built in
    step(1, 24, 1, REQ | IRL, 0);
    step(1, 24, 0, 0, 0);
    step(1, 24, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 24, 0, REQ | SEL, 0);
`ifdef SEQ_MEM_TIMEOUT_EN
    step(1, 24, 0, HLT | TMO, 0);
    step(1, 24, 1, HLT | TMO, 0);
`else
    step(1, 24, 0, REQ | SEL, 0);
    step(1, 24, 0, REQ | SEL, 0);
`endif
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending act=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
